// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the data-memory handshake for loads/stores and
// produces the registered MEM/WB fields. EX is stalled while a transaction is outstanding.
module mem_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_funct3,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_ready,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_misaligned
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]       addr_q, wdata_q;
  logic [3:0]            wstrb_q;
  logic                  we_q, reg_write_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [2:0]            funct3_q;

  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  wb_misaligned_q, wb_misaligned_d;

  logic [1:0]      ex_off;
  logic            is_mem, misaligned, accept;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  assign ex_ready   = (state_q == StIdle);
  assign accept     = ex_valid && ex_ready;
  assign ex_off     = ex_alu_result[1:0];
  assign is_mem     = ex_mem_read || ex_mem_write;
  assign misaligned = is_mem && (((ex_funct3[1:0] == 2'b01) && ex_off[0]) ||
                                 ((ex_funct3[1:0] == 2'b10) && (ex_off != 2'b00)));

  // Store lanes are replicated so the memory only needs the strobes to pick bytes.
  always_comb begin
    st_strb  = 4'hF;
    st_wdata = ex_store_data;
    unique case (ex_funct3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << ex_off;
        st_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        st_strb  = 4'b0011 << ex_off;
        st_wdata = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = dmem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = dmem_rdata;
    unique case (funct3_q[1:0])
      2'b00:   ld_data = {{(XLEN-8){ld_byte[7] & ~funct3_q[2]}}, ld_byte};
      2'b01:   ld_data = {{(XLEN-16){ld_half[15] & ~funct3_q[2]}}, ld_half};
      default: ;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    wb_valid_d      = 1'b0;
    wb_rd_d         = wb_rd_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_data_d       = wb_data_q;
    wb_misaligned_d = wb_misaligned_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d      = 1'b1;
            wb_rd_d         = ex_rd;
            wb_reg_write_d  = ex_reg_write;
            wb_data_d       = ex_alu_result;
            wb_misaligned_d = 1'b0;
          end else if (misaligned) begin
            wb_valid_d      = 1'b1;
            wb_rd_d         = ex_rd;
            wb_reg_write_d  = 1'b0;
            wb_misaligned_d = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (dmem_ready) begin
          if (we_q) begin
            wb_valid_d      = 1'b1;
            wb_rd_d         = rd_q;
            wb_reg_write_d  = 1'b0;
            wb_misaligned_d = 1'b0;
            state_d         = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (dmem_rvalid) begin
          wb_valid_d      = 1'b1;
          wb_rd_d         = rd_q;
          wb_reg_write_d  = reg_write_q;
          wb_data_d       = ld_data;
          wb_misaligned_d = 1'b0;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      we_q            <= 1'b0;
      reg_write_q     <= 1'b0;
      rd_q            <= '0;
      funct3_q        <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_data_q       <= '0;
      wb_misaligned_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_data_q       <= wb_data_d;
      wb_misaligned_q <= wb_misaligned_d;
      if (accept) begin
        addr_q      <= ex_alu_result;
        wdata_q     <= st_wdata;
        wstrb_q     <= ex_mem_write ? st_strb : 4'h0;
        we_q        <= ex_mem_write;
        reg_write_q <= ex_reg_write;
        rd_q        <= ex_rd;
        funct3_q    <= ex_funct3;
      end
    end
  end

  assign dmem_req   = (state_q == StReq);
  assign dmem_we    = dmem_req && we_q;
  assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = dmem_req ? wstrb_q : 4'h0;

  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_data       = wb_data_q;
  assign wb_misaligned = wb_misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand sequences for reset/throughput corners,
// and randomized transactions checked against an arithmetic reference model.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        wb_misaligned;

  int tests = 0;
  int failed = 0;

  mem_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_ready    (dmem_ready),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .wb_misaligned (wb_misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          rdly;
    int          vdly;
    logic        spur;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic        exp_mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid      = 1'b0;
    ex_alu_result = '0;
    ex_store_data = '0;
    ex_rd         = '0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_funct3     = '0;
  endtask

  // Reference model: expected results derived from the sizing rules with plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        r = v;
    int unsigned off, size, lane;
    logic [31:0] val;
    off  = v.alu % 4;
    size = v.f3 % 4;
    r.exp_mis   = (v.mr || v.mw) && ((size == 1 && (off % 2) == 1) || (size == 2 && off != 0));
    r.exp_strb  = 4'h0;
    r.exp_wdata = '0;
    r.exp_data  = v.alu;
    r.exp_rw    = v.rw && !v.mw && !r.exp_mis;
    if (v.mw) begin
      if (size == 0) begin
        r.exp_strb  = 4'(1 << off);
        r.exp_wdata = (v.sdata % 256) * 32'h0101_0101;
      end else if (size == 1) begin
        r.exp_strb  = 4'(3 << off);
        r.exp_wdata = (v.sdata % 65536) * 32'h0001_0001;
      end else begin
        r.exp_strb  = 4'hF;
        r.exp_wdata = v.sdata;
      end
    end else if (v.mr) begin
      if (size == 0) begin
        val = (v.rdata >> (8 * off)) % 256;
        if (v.f3 < 4 && val >= 128) val = val - 256;
      end else if (size == 1) begin
        lane = off / 2;
        val  = (v.rdata >> (16 * lane)) % 65536;
        if (v.f3 < 4 && val >= 32768) val = val - 65536;
      end else begin
        val = v.rdata;
      end
      r.exp_data = val;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    ex_valid      = 1'b1;
    ex_alu_result = v.alu;
    ex_store_data = v.sdata;
    ex_rd         = v.rd;
    ex_reg_write  = v.rw;
    ex_mem_read   = v.mr;
    ex_mem_write  = v.mw;
    ex_funct3     = v.f3;
    check({tag, ".ex_ready_accept"}, 32'(ex_ready), 32'd1);
    tick();
    idle_inputs();
    if (v.exp_mis || !(v.mr || v.mw)) begin
      check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      check({tag, ".wb_misaligned"}, 32'(wb_misaligned), 32'(v.exp_mis));
      check({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'(v.exp_rw));
      check({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
      check({tag, ".ex_ready"}, 32'(ex_ready), 32'd1);
      if (!v.exp_mis) begin
        check({tag, ".wb_data"}, wb_data, v.exp_data);
        check({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
      end
    end else begin
      for (int c = 0; c <= v.rdly; c++) begin
        check({tag, ".req"}, 32'(dmem_req), 32'd1);
        check({tag, ".we"}, 32'(dmem_we), 32'(v.mw));
        check({tag, ".addr"}, dmem_addr, v.alu & 32'hFFFF_FFFC);
        check({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(v.exp_strb));
        if (v.mw) check({tag, ".wdata"}, dmem_wdata, v.exp_wdata);
        check({tag, ".ex_ready_busy"}, 32'(ex_ready), 32'd0);
        check({tag, ".wb_valid_busy"}, 32'(wb_valid), 32'd0);
        dmem_ready  = (c == v.rdly);
        dmem_rvalid = v.spur && (c < v.rdly);
        dmem_rdata  = ~v.rdata;
        tick();
      end
      dmem_ready  = 1'b0;
      dmem_rvalid = 1'b0;
      if (!v.mw) begin
        for (int c = 0; c <= v.vdly; c++) begin
          check({tag, ".req_wait"}, 32'(dmem_req), 32'd0);
          check({tag, ".wb_valid_wait"}, 32'(wb_valid), 32'd0);
          check({tag, ".ex_ready_wait"}, 32'(ex_ready), 32'd0);
          dmem_rvalid = (c == v.vdly);
          dmem_rdata  = (c == v.vdly) ? v.rdata : ~v.rdata;
          tick();
        end
        dmem_rvalid = 1'b0;
        check({tag, ".wb_data"}, wb_data, v.exp_data);
        check({tag, ".wb_rd"}, 32'(wb_rd), 32'(v.rd));
      end
      check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
      check({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'(v.exp_rw));
      check({tag, ".wb_misaligned"}, 32'(wb_misaligned), 32'd0);
      check({tag, ".ex_ready_done"}, 32'(ex_ready), 32'd1);
    end
    tick();
    check({tag, ".wb_pulse"}, 32'(wb_valid), 32'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] sdata,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic mw, input logic [2:0] f3, input logic [31:0] rdata,
                              input int rdly, input int vdly, input logic spur,
                              input logic [31:0] exp_data, input logic exp_rw,
                              input logic exp_mis, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.alu = alu; v.sdata = sdata; v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw; v.f3 = f3;
    v.rdata = rdata; v.rdly = rdly; v.vdly = vdly; v.spur = spur;
    v.exp_data = exp_data; v.exp_rw = exp_rw; v.exp_mis = exp_mis;
    v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  vec_t table_v[$];
  vec_t rv;

  initial begin
    // Hand-computed expectations.
    table_v.push_back(mk(32'h103, 0, 5, 1, 1, 0, 3'b000, 32'h80FF_0000, 0, 0, 0,
                         32'hFFFF_FF80, 1, 0, 4'h0, 0));
    table_v.push_back(mk(32'h103, 0, 6, 1, 1, 0, 3'b100, 32'h80FF_0000, 0, 0, 0,
                         32'h0000_0080, 1, 0, 4'h0, 0));
    table_v.push_back(mk(32'h202, 32'h0000_ABCD, 0, 0, 0, 1, 3'b001, 0, 3, 0, 0,
                         0, 0, 0, 4'b1100, 32'hABCD_ABCD));
    table_v.push_back(mk(32'h101, 0, 9, 1, 1, 0, 3'b010, 0, 0, 0, 0,
                         0, 0, 1, 4'h0, 0));
    table_v.push_back(mk(32'h102, 0, 10, 1, 1, 0, 3'b001, 32'h8765_1234, 1, 1, 0,
                         32'hFFFF_8765, 1, 0, 4'h0, 0));
    table_v.push_back(mk(32'h102, 0, 11, 1, 1, 0, 3'b101, 32'h8765_1234, 0, 0, 0,
                         32'h0000_8765, 1, 0, 4'h0, 0));
    table_v.push_back(mk(32'h301, 32'h1234_56A5, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0,
                         0, 0, 0, 4'b0010, 32'hA5A5_A5A5));
    table_v.push_back(mk(32'h400, 32'hDEAD_BEEF, 0, 0, 0, 1, 3'b010, 0, 1, 0, 0,
                         0, 0, 0, 4'hF, 32'hDEAD_BEEF));
    table_v.push_back(mk(32'h404, 0, 12, 1, 1, 0, 3'b010, 32'hCAFE_F00D, 2, 2, 1,
                         32'hCAFE_F00D, 1, 0, 4'h0, 0));
    table_v.push_back(mk(32'h1234_5678, 0, 7, 1, 0, 0, 3'b000, 0, 0, 0, 0,
                         32'h1234_5678, 1, 0, 4'h0, 0));
    table_v.push_back(mk(32'h001, 32'h5555, 0, 0, 0, 1, 3'b001, 0, 0, 0, 0,
                         0, 0, 1, 4'h0, 0));
    table_v.push_back(mk(32'h102, 0, 13, 0, 1, 0, 3'b000, 32'h0011_7F00, 0, 0, 0,
                         32'h0000_0011, 0, 0, 4'h0, 0));

    reset       = 1'b0;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    idle_inputs();
    tick();
    tick();
    check("reset.wb_valid", 32'(wb_valid), 32'd0);
    check("reset.wb_rd", 32'(wb_rd), 32'd0);
    check("reset.wb_data", wb_data, 32'd0);
    check("reset.wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("reset.wb_misaligned", 32'(wb_misaligned), 32'd0);
    check("reset.dmem_req", 32'(dmem_req), 32'd0);
    check("reset.dmem_we", 32'(dmem_we), 32'd0);
    check("reset.dmem_wstrb", 32'(dmem_wstrb), 32'd0);
    check("reset.ex_ready", 32'(ex_ready), 32'd1);
    reset = 1'b1;
    tick();

    foreach (table_v[i]) run_txn(table_v[i], $sformatf("vec%0d", i));

    // Back-to-back ALU stream: one retirement per cycle, never stalling.
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        ex_valid      = 1'b1;
        ex_rd         = 5'(k + 1);
        ex_alu_result = 32'h10 + 32'(k);
        ex_reg_write  = 1'b1;
        check("alu_stream.ex_ready", 32'(ex_ready), 32'd1);
      end else begin
        idle_inputs();
      end
      if (k > 0) begin
        check("alu_stream.wb_valid", 32'(wb_valid), 32'd1);
        check("alu_stream.wb_rd", 32'(wb_rd), 32'(k));
        check("alu_stream.wb_data", wb_data, 32'h10 + 32'(k - 1));
      end
      tick();
    end
    check("alu_stream.wb_pulse", 32'(wb_valid), 32'd0);

    // Reset during WAIT abandons the load; a late rvalid must not retire anything.
    ex_valid      = 1'b1;
    ex_alu_result = 32'h100;
    ex_rd         = 5'd3;
    ex_reg_write  = 1'b1;
    ex_mem_read   = 1'b1;
    ex_funct3     = 3'b010;
    tick();
    idle_inputs();
    check("rst_wait.req", 32'(dmem_req), 32'd1);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    check("rst_wait.in_wait", 32'(dmem_req | ex_ready), 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_wait.ex_ready", 32'(ex_ready), 32'd1);
    check("rst_wait.wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wait.wb_data", wb_data, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    tick();
    dmem_rvalid = 1'b0;
    check("rst_wait.wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wait.wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("rst_wait.wb_data_late", wb_data, 32'd0);
    check("rst_wait.ex_ready_late", 32'(ex_ready), 32'd1);
    tick();
    check("rst_wait.wb_valid_late", 32'(wb_valid), 32'd0);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      kind     = $urandom_range(0, 2);
      rv.alu   = $urandom;
      rv.sdata = $urandom;
      rv.rd    = 5'($urandom);
      rv.rw    = 1'($urandom);
      rv.mr    = (kind == 1);
      rv.mw    = (kind == 2);
      rv.rdata = $urandom;
      rv.rdly  = $urandom_range(0, 3);
      rv.vdly  = $urandom_range(0, 3);
      rv.spur  = 1'($urandom);
      if (kind == 1) begin
        case ($urandom_range(0, 4))
          0: rv.f3 = 3'b000;
          1: rv.f3 = 3'b001;
          2: rv.f3 = 3'b010;
          3: rv.f3 = 3'b100;
          default: rv.f3 = 3'b101;
        endcase
      end else begin
        rv.f3 = 3'($urandom_range(0, 2));
      end
      rv = model(rv);
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
